// File: rtl/cache2w_ctrl.sv
// Controller for a 2-way set-associative write-back LRU cache: tag/valid/dirty/LRU metadata,
// lookup, victim write-back and block fill sequencing. Optional counters under `PERF_CNT_EN`.
module cache2w_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int OFFSET_W = 4,
  parameter int INDEX_W  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  output logic               cpu_ready,
  output logic               cpu_hit,
  output logic [INDEX_W-1:0] da_set,
  output logic               da_way,
  output logic [1:0]         da_word,
  output logic               da_wr_word,
  output logic               da_fill,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]        hit_cnt,
  output logic [15:0]        miss_cnt,
  output logic [15:0]        wb_cnt
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS  = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    WB     = 2'd2,
    FILL   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic              miss_flag;
  logic              victim;

  logic [TAG_W-1:0]  tag_q   [SETS][2];
  logic [1:0]        valid_q [SETS];
  logic [1:0]        dirty_q [SETS];
  logic [SETS-1:0]   lru_q;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_set;
  logic               hit0, hit1, hit, hit_way;
  logic               victim_sel, victim_dirty;
  logic               unused_bits;

  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
  assign req_set = req_addr[OFFSET_W +: INDEX_W];
  assign unused_bits = ^req_addr[OFFSET_W-3:0];

  assign hit0    = valid_q[req_set][0] && (tag_q[req_set][0] == req_tag);
  assign hit1    = valid_q[req_set][1] && (tag_q[req_set][1] == req_tag);
  assign hit     = hit0 || hit1;
  assign hit_way = !hit0;

  // An invalid way is always preferred over evicting live data; LRU breaks the tie otherwise.
  always_comb begin
    victim_sel = lru_q[req_set];
    if (!valid_q[req_set][0])
      victim_sel = 1'b0;
    else if (!valid_q[req_set][1])
      victim_sel = 1'b1;
  end

  assign victim_dirty = valid_q[req_set][victim_sel] && dirty_q[req_set][victim_sel];

  assign da_set  = req_set;
  assign da_word = req_addr[OFFSET_W-1 -: 2];

  always_comb begin
    state_nxt  = state;
    cpu_ready  = 1'b0;
    cpu_hit    = 1'b0;
    da_way     = 1'b0;
    da_wr_word = 1'b0;
    da_fill    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    case (state)
      IDLE: begin
        if (cpu_req)
          state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          cpu_ready  = 1'b1;
          cpu_hit    = !miss_flag;
          da_way     = hit_way;
          da_wr_word = req_we;
          state_nxt  = IDLE;
        end else begin
          state_nxt = victim_dirty ? WB : FILL;
        end
      end
      WB: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {tag_q[req_set][victim], req_set, {OFFSET_W{1'b0}}};
        da_way   = victim;
        if (mem_ack)
          state_nxt = FILL;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_set, {OFFSET_W{1'b0}}};
        da_way   = victim;
        if (mem_ack) begin
          da_fill   = 1'b1;
          state_nxt = LOOKUP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A fill returns to LOOKUP rather than completing directly, so every access ends on a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_we    <= 1'b0;
      req_addr  <= '0;
      miss_flag <= 1'b0;
      victim    <= 1'b0;
      lru_q     <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            miss_flag <= 1'b0;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (req_we)
              dirty_q[req_set][hit_way] <= 1'b1;
            lru_q[req_set] <= !hit_way;
          end else begin
            miss_flag <= 1'b1;
            victim    <= victim_sel;
          end
        end
        WB: begin
          if (mem_ack)
            dirty_q[req_set][victim] <= 1'b0;
        end
        FILL: begin
          if (mem_ack) begin
            valid_q[req_set][victim] <= 1'b1;
            dirty_q[req_set][victim] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tags are meaningful only while their valid bit is set, so they need no reset.
  always_ff @(posedge clk) begin
    if (!rst && state == FILL && mem_ack)
      tag_q[req_set][victim] <= req_tag;
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (cpu_ready && cpu_hit && hit_cnt != 16'hFFFF)
        hit_cnt <= hit_cnt + 16'd1;
      if (cpu_ready && !cpu_hit && miss_cnt != 16'hFFFF)
        miss_cnt <= miss_cnt + 16'd1;
      if (state == WB && mem_ack && wb_cnt != 16'hFFFF)
        wb_cnt <= wb_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache2w_ctrl.sv
// Bench for cache2w_ctrl: directed scenarios plus random accesses checked against an
// abstract per-set cache model; a stalling memory responder acknowledges block transfers.
module tb_cache2w_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we;
  logic [9:0] cpu_addr;
  logic       cpu_ready, cpu_hit;
  logic       da_set, da_way, da_wr_word, da_fill;
  logic [1:0] da_word;
  logic       mem_req, mem_we, mem_ack;
  logic [9:0] mem_addr;
`ifdef PERF_CNT_EN
  logic [15:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Abstract model: per set, each way's valid/tag/dirty and the most recently used way.
  bit       mv  [2][2];
  bit [4:0] mt  [2][2];
  bit       md  [2][2];
  int       mru [2];
  int       exp_hits, exp_misses, exp_wbs;

  cache2w_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_ready  (cpu_ready),
    .cpu_hit    (cpu_hit),
    .da_set     (da_set),
    .da_way     (da_way),
    .da_word    (da_word),
    .da_wr_word (da_wr_word),
    .da_fill    (da_fill),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack)
`ifdef PERF_CNT_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .wb_cnt     (wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 2; w++) begin
        mv[s][w] = 1'b0;
        md[s][w] = 1'b0;
        mt[s][w] = '0;
      end
      mru[s] = 1;
    end
    exp_hits = 0;
    exp_misses = 0;
    exp_wbs = 0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_da_fill", 32'(da_fill), 32'd0);
    checkOutput("rst_da_wr_word", 32'(da_wr_word), 32'd0);
  endtask

  // One full CPU access; expectations come from the model before it is updated.
  task automatic applyStimulus(input logic we, input logic [9:0] addr);
    int  s, t, v, cyc, stall, cur, exp_lat, fill_done;
    bit  exp_hit, exp_wb, wb_done, done;
    logic [9:0] wb_addr, fill_addr;
    s = int'(addr[4]);
    t = int'(addr[9:5]);
    exp_hit = 1'b0;
    v = 0;
    if (mv[s][0] && mt[s][0] == 5'(t)) begin exp_hit = 1'b1; v = 0; end
    else if (mv[s][1] && mt[s][1] == 5'(t)) begin exp_hit = 1'b1; v = 1; end
    else if (!mv[s][0]) v = 0;
    else if (!mv[s][1]) v = 1;
    else v = 1 - mru[s];
    exp_wb    = !exp_hit && mv[s][v] && md[s][v];
    wb_addr   = {mt[s][v], addr[4], 4'b0000};
    fill_addr = {addr[9:5], addr[4], 4'b0000};

    @(posedge clk);
    #1;
    mem_ack  = 1'b0;
    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_addr = addr;
    cyc = 0;
    done = 1'b0;
    wb_done = 1'b0;
    fill_done = 0;
    exp_lat = exp_hit ? 1 : 2;
    cur = int'($urandom_range(0, 5));
    stall = cur;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      mem_ack = 1'b0;
      if (cyc == 1) begin
        cpu_addr = 10'($urandom);
        cpu_we   = 1'($urandom);
      end
      #1;
      if (cpu_ready) begin
        done = 1'b1;
        checkOutput("cpu_hit", 32'(cpu_hit), 32'(exp_hit));
        checkOutput("ready_way", 32'(da_way), 32'(v));
        checkOutput("ready_set", 32'(da_set), 32'(addr[4]));
        checkOutput("ready_word", 32'(da_word), 32'(addr[3:2]));
        checkOutput("wr_word", 32'(da_wr_word), 32'(we));
        checkOutput("latency", 32'(cyc), 32'(exp_lat));
        checkOutput("wb_seen", 32'(wb_done), 32'(exp_wb));
        checkOutput("fills_seen", 32'(fill_done), exp_hit ? 32'd0 : 32'd1);
        cpu_req = 1'b0;
        mem_ack = 1'($urandom);
      end else if (mem_req) begin
        if (stall == 0) begin
          exp_lat += cur + 1;
          mem_ack = 1'b1;
          #1;
          if (exp_wb && !wb_done) begin
            checkOutput("wb_mem_we", 32'(mem_we), 32'd1);
            checkOutput("wb_mem_addr", 32'(mem_addr), 32'(wb_addr));
            checkOutput("wb_way", 32'(da_way), 32'(v));
            wb_done = 1'b1;
          end else begin
            checkOutput("fill_mem_we", 32'(mem_we), 32'd0);
            checkOutput("fill_mem_addr", 32'(mem_addr), 32'(fill_addr));
            checkOutput("fill_strobe", 32'(da_fill), 32'd1);
            checkOutput("fill_way", 32'(da_way), 32'(v));
            fill_done++;
          end
          cur = int'($urandom_range(0, 5));
          stall = cur;
        end else begin
          stall--;
        end
      end else if (cyc == 1) begin
        mem_ack = 1'($urandom);
      end
    end
    checkOutput("access_done", 32'(done), 32'd1);
    cpu_req = 1'b0;

    if (exp_hit) exp_hits++;
    else exp_misses++;
    if (exp_wb) exp_wbs++;
    if (!exp_hit) begin
      mv[s][v] = 1'b1;
      mt[s][v] = addr[9:5];
      md[s][v] = 1'b0;
    end
    mru[s] = v;
    if (we) md[s][v] = 1'b1;
  endtask

  initial begin
    int n;
    logic [9:0] a;
    doReset();

    applyStimulus(1'b0, 10'h000);
    applyStimulus(1'b1, 10'h000);
    applyStimulus(1'b0, 10'h200);
    applyStimulus(1'b0, 10'h000);
    applyStimulus(1'b0, 10'h300);
    applyStimulus(1'b0, 10'h200);
`ifdef PERF_CNT_EN
    checkOutput("hit_cnt_dir", 32'(hit_cnt), 32'd2);
    checkOutput("miss_cnt_dir", 32'(miss_cnt), 32'd4);
    checkOutput("wb_cnt_dir", 32'(wb_cnt), 32'd1);
`endif

    doReset();
    @(posedge clk);
    #1;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 10'h000;
    n = 0;
    while (!mem_req && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("fill_pending", 32'(mem_req), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_fill_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_fill_ready", 32'(cpu_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_fill_ready2", 32'(cpu_ready), 32'd0);
    applyStimulus(1'b0, 10'h000);

    for (int i = 0; i < 80; i++) begin
      a = {3'b000, 2'($urandom_range(0, 3)), 1'($urandom), 2'($urandom), 2'($urandom)};
      applyStimulus(1'($urandom), a);
    end
`ifdef PERF_CNT_EN
    checkOutput("hit_cnt_rand", 32'(hit_cnt), 32'(exp_hits));
    checkOutput("miss_cnt_rand", 32'(miss_cnt), 32'(exp_misses));
    checkOutput("wb_cnt_rand", 32'(wb_cnt), 32'(exp_wbs));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
